// File: rtl/nmix_pkg.sv
// Shared definitions for the nmix mixer/inverse pair: word width, FSM states
// and the golden forward mix function.
package nmix_pkg;

    localparam int NMIX_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } nmix_state_e;

    // Forward mix: Y[k] = X[k] ^ R[k] ^ (XOR of X[j] & R[j] for all j < k).
    function automatic logic [NMIX_W-1:0] nmix_ref(input logic [NMIX_W-1:0] x,
                                                   input logic [NMIX_W-1:0] r);
        logic              c;
        logic [NMIX_W-1:0] y;
        c = 1'b0;
        y = '0;
        for (int k = 0; k < NMIX_W; k++) begin
            y[k] = x[k] ^ r[k] ^ c;
            c    = c ^ (x[k] & r[k]);
        end
        return y;
    endfunction

endpackage

// File: rtl/nmix_inv_step.sv
// One bit of the inverse recurrence: recovers x from y, r and the running
// carry, and produces the carry for the next bit.
module nmix_inv_step (
    input  logic i_y_b,
    input  logic i_r_b,
    input  logic i_c_in,
    output logic o_x_b,
    output logic o_c_out
);

    assign o_x_b   = i_y_b ^ i_r_b ^ i_c_in;
    assign o_c_out = i_c_in ^ (o_x_b & i_r_b);

endmodule

// File: rtl/nmix_inv.sv
// Bit-serial inverse of nmix: recovers X from (Y, R), one bit per clock,
// LSB first. X is published only on completion and held until the next one.
module nmix_inv
    import nmix_pkg::*;
#(
    parameter int W = NMIX_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] Y,
    input  logic [W-1:0] R,
    output logic [W-1:0] X,
    output logic         busy,
    output logic         done
);

    localparam int KW = $clog2(W);

    nmix_state_e  r_state;
    nmix_state_e  w_state_next;
    logic [KW-1:0] r_k;
    logic          r_c;
    logic [W-1:0]  r_y;
    logic [W-1:0]  r_r;
    logic [W-2:0]  r_x_work;
    logic [W-1:0]  r_x;
    logic          r_busy;
    logic          r_done;

    logic w_accept;
    logic w_last;
    logic w_x_b;
    logic w_c_out;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_k == KW'(W - 1));

    nmix_inv_step u_step (
        .i_y_b   (r_y[r_k]),
        .i_r_b   (r_r[r_k]),
        .i_c_in  (r_c),
        .o_x_b   (w_x_b),
        .o_c_out (w_c_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath; the top result bit goes straight from the step into X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k      <= '0;
            r_c      <= 1'b0;
            r_y      <= '0;
            r_r      <= '0;
            r_x_work <= '0;
            r_x      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (r_state == IDLE) begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_y      <= Y;
                r_r      <= R;
                r_k      <= '0;
                r_c      <= 1'b0;
                r_x_work <= '0;
                r_busy   <= 1'b1;
            end
        end else begin
            r_c <= w_c_out;
            if (w_last) begin
                r_x    <= {w_x_b, r_x_work};
                r_done <= 1'b1;
                r_busy <= 1'b0;
                r_k    <= '0;
            end else begin
                r_x_work[r_k] <= w_x_b;
                r_k           <= r_k + KW'(1);
            end
        end
    end

    assign X    = r_x;
    assign busy = r_busy;
    assign done = r_done;

endmodule
